lsu_bus_master: RTL

//   Load/store unit bus master: accepts one CPU load/store request at a time, turns it into a single

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/wb_bus.sv | 15 +
 rtl/lsu_lane_align.sv | 42 ++++
 rtl/lsu_bus_master.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit bus master.
package lsu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } lsu_size_t;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t IDLE     = 2'd0;
    localparam lsu_state_t BUS      = 2'd1;
    localparam lsu_state_t DONE     = 2'd2;
    localparam lsu_state_t ERR_RESP = 2'd3;

    // Size 2'b11 has no legal encoding and is reported like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = offset[0];
            SIZE_WORD: mis = (offset != 2'b00);
            default:   mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/wb_bus.sv
// Wishbone classic bus bundle between the LSU master and the interconnect slaves.
interface wb_bus;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;

    modport master (output addr, wdata, sel, we, cyc, stb, input rdata, ack, err);
    modport slave  (input addr, wdata, sel, we, cyc, stb, output rdata, ack, err);
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data replication / byte enables, and load data extraction with extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  sel_c,
    output logic [31:0] wdata_c,
    output logic [31:0] load_data_c
);

    logic [31:0] shifted;

    always_comb begin
        shifted     = bus_rdata >> {offset, 3'b000};
        sel_c       = '0;
        wdata_c     = store_data;
        load_data_c = shifted;
        case (size)
            SIZE_BYTE: begin
                sel_c       = 4'b0001 << offset;
                wdata_c     = {4{store_data[7:0]}};
                load_data_c = is_unsigned ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                sel_c       = 4'b0011 << offset;
                wdata_c     = {2{store_data[15:0]}};
                load_data_c = is_unsigned ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            end
            SIZE_WORD: begin
                sel_c = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// LSU bus master: one CPU load/store at a time turned into a single wishbone classic cycle.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    wb_bus.master       bus_master
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TimeoutCycles - 1);

    lsu_state_t       state_q, state_d;
    logic [1:0]       size_q, size_d;
    logic [1:0]       off_q, off_d;
    logic             uns_q, uns_d;
    logic             cyc_q, cyc_d;
    logic             bwe_q, bwe_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             rvalid_q, rvalid_d;
    logic             rerr_q, rerr_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;

    logic             idle;
    logic [1:0]       al_size, al_off;
    logic             al_uns;
    logic [SEL_W-1:0] al_sel;
    logic [XLEN-1:0]  al_wdata, al_load;

    // In IDLE the aligner shapes the incoming request; otherwise it extracts the load from rdata.
    assign idle    = (state_q == IDLE);
    assign al_size = idle ? req_size : size_q;
    assign al_off  = idle ? req_addr[1:0] : off_q;
    assign al_uns  = idle ? req_unsigned : uns_q;

    lsu_lane_align u_align (
        .size        (al_size),
        .offset      (al_off),
        .is_unsigned (al_uns),
        .store_data  (req_wdata),
        .bus_rdata   (bus_master.rdata),
        .sel_c       (al_sel),
        .wdata_c     (al_wdata),
        .load_data_c (al_load)
    );

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q  <= IDLE;
            size_q   <= '0;
            off_q    <= '0;
            uns_q    <= 1'b0;
            cyc_q    <= 1'b0;
            bwe_q    <= 1'b0;
            sel_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            off_q    <= off_d;
            uns_q    <= uns_d;
            cyc_q    <= cyc_d;
            bwe_q    <= bwe_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        off_d    = off_q;
        uns_d    = uns_q;
        cyc_d    = cyc_q;
        bwe_d    = bwe_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        rdata_d  = '0;

        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    size_d = req_size;
                    off_d  = req_addr[1:0];
                    uns_d  = req_unsigned;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d  = ERR_RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end else begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                        bwe_d   = req_we;
                        sel_d   = al_sel;
                        addr_d  = {req_addr[31:2], 2'b00};
                        wdata_d = al_wdata;
                        cnt_d   = '0;
                    end
                end
            end
            BUS: begin
                // err has priority over ack; timeout fires on the edge the count reaches the limit.
                if (bus_master.err || bus_master.ack || cnt_q == TIMEOUT_LAST) begin
                    state_d  = DONE;
                    cyc_d    = 1'b0;
                    bwe_d    = 1'b0;
                    rvalid_d = 1'b1;
                    if (bus_master.ack && !bus_master.err) begin
                        rdata_d = bwe_q ? '0 : al_load;
                    end else begin
                        rerr_d = 1'b1;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_d = (state_d == IDLE);

    assign req_ready        = ready_q;
    assign resp_valid       = rvalid_q;
    assign resp_rdata       = rdata_q;
    assign resp_err         = rerr_q;
    assign bus_master.cyc   = cyc_q;
    assign bus_master.stb   = cyc_q;
    assign bus_master.we    = bwe_q;
    assign bus_master.sel   = sel_q;
    assign bus_master.addr  = addr_q;
    assign bus_master.wdata = wdata_q;

endmodule
